// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator motion/scheduling stage.
// Floor encodings, FSM states, door-stage status codes and floor-mask helpers.
package elevator_pkg;

    typedef logic [1:0] floor_t;

    localparam floor_t ST_FLOOR = 2'b00;
    localparam floor_t ND_FLOOR = 2'b01;
    localparam floor_t RD_FLOOR = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVE   = 2'd1,
        ARRIVE = 2'd2,
        STOP   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        DOOR_CLOSED  = 2'd0,
        DOOR_OPENING = 2'd1,
        DOOR_OPEN    = 2'd2,
        DOOR_CLOSING = 2'd3
    } door_status_t;

    // Call-bit masks for the floors strictly above / below a given floor.
    function automatic logic [2:0] above_mask(input floor_t f);
        case (f)
            ST_FLOOR: return 3'b110;
            ND_FLOOR: return 3'b100;
            default:  return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] below_mask(input floor_t f);
        case (f)
            ND_FLOOR: return 3'b001;
            RD_FLOOR: return 3'b011;
            default:  return 3'b000;
        endcase
    endfunction

    function automatic logic call_at(input logic [2:0] calls, input floor_t f);
        case (f)
            ST_FLOOR: return calls[0];
            ND_FLOOR: return calls[1];
            RD_FLOOR: return calls[2];
            default:  return 1'b0;
        endcase
    endfunction

    // One floor in the given direction, saturating at the end floors.
    function automatic floor_t step_floor(input floor_t f, input logic up);
        if (up)
            return (f == RD_FLOOR) ? RD_FLOOR : floor_t'(f + 2'd1);
        else
            return (f == ST_FLOOR) ? ST_FLOOR : floor_t'(f - 2'd1);
    endfunction

endpackage

// File: rtl/elevator_motion_ctrl_call_latch.sv
// Pending-call register behind the floor LEDs: set by call buttons, cleared
// when the door cycle at that floor completes; clear beats set.
module call_latch
    import elevator_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] call_btn,
    input  logic       clear_en,
    input  floor_t     clear_floor,
    input  logic       block_en,
    input  floor_t     block_floor,
    output logic [2:0] leds
);

    logic [2:0] set_mask;
    logic [2:0] clr_mask;

    always_comb begin
        set_mask = call_btn;
        clr_mask = 3'b000;
        for (int i = 0; i < 3; i++) begin
            if (block_en && block_floor == floor_t'(i))
                set_mask[i] = 1'b0;
            if (clear_en && clear_floor == floor_t'(i))
                clr_mask[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            leds <= 3'b000;
        else
            leds <= (leds | set_mask) & ~clr_mask;
    end

endmodule

// File: rtl/elevator_motion_ctrl.sv
// Three-floor elevator motion controller: latches calls, picks a direction,
// steps the cab with a travel timer and hands arrivals to the door stage.
module elevator_motion_ctrl
    import elevator_pkg::*;
#(
    parameter int unsigned TRAVEL_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] call_btn,
    input  logic       emergency,
    input  logic       door_done,
    output logic [1:0] floor,
    output logic [1:0] next_floor,
    output logic [1:0] open_when,
    output logic       open_req,
    output logic       is_mooving,
    output logic       dir_up,
    output logic       st_led,
    output logic       nd_led,
    output logic       rd_led
);

    localparam logic [7:0] TIMER_LOAD = 8'(TRAVEL_CYCLES - 1);

    state_t     state, state_nxt;
    state_t     saved, saved_nxt;
    logic [7:0] timer, timer_nxt;
    floor_t     floor_nxt, next_floor_nxt, stepped;
    logic       dir_nxt, eff_up, ahead_idle, behind_idle, ahead_after;
    logic [2:0] leds;

    call_latch u_call_latch (
        .clk         (clk),
        .rst_n       (rst_n),
        .call_btn    (call_btn),
        .clear_en    (state == ARRIVE && door_done),
        .clear_floor (floor),
        .block_en    (state == ARRIVE),
        .block_floor (floor),
        .leds        (leds)
    );

    assign {rd_led, nd_led, st_led} = leds;
    assign open_req   = (state == ARRIVE);
    assign is_mooving = (state == MOVE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            saved      <= IDLE;
            timer      <= 8'd0;
            floor      <= ST_FLOOR;
            dir_up     <= 1'b1;
            next_floor <= ST_FLOOR;
            open_when  <= ST_FLOOR;
        end else begin
            state      <= state_nxt;
            saved      <= saved_nxt;
            timer      <= timer_nxt;
            floor      <= floor_nxt;
            dir_up     <= dir_nxt;
            next_floor <= next_floor_nxt;
            open_when  <= floor_nxt;
        end
    end

    // End floors force the direction when a new trip is chosen from IDLE.
    always_comb begin
        state_nxt   = state;
        saved_nxt   = saved;
        timer_nxt   = timer;
        floor_nxt   = floor;
        dir_nxt     = dir_up;
        eff_up      = (floor == RD_FLOOR) ? 1'b0 : (floor == ST_FLOOR) ? 1'b1 : dir_up;
        ahead_idle  = |(leds & (eff_up ? above_mask(floor) : below_mask(floor)));
        behind_idle = |(leds & (eff_up ? below_mask(floor) : above_mask(floor)));
        stepped     = step_floor(floor, dir_up);
        ahead_after = |(leds & (dir_up ? above_mask(stepped) : below_mask(stepped)));

        if (floor == 2'b11) begin
            state_nxt = IDLE;
            floor_nxt = ST_FLOOR;
        end else begin
            case (state)
                IDLE: begin
                    if (emergency) begin
                        saved_nxt = IDLE;
                        state_nxt = STOP;
                    end else if (call_at(leds, floor)) begin
                        state_nxt = ARRIVE;
                    end else if (ahead_idle || behind_idle) begin
                        dir_nxt   = ahead_idle ? eff_up : ~eff_up;
                        timer_nxt = TIMER_LOAD;
                        state_nxt = MOVE;
                    end
                end
                MOVE: begin
                    if (emergency) begin
                        saved_nxt = MOVE;
                        state_nxt = STOP;
                    end else if (timer != 8'd0) begin
                        timer_nxt = timer - 8'd1;
                    end else begin
                        floor_nxt = stepped;
                        // A button pressed at the new floor in this very cycle still stops the cab.
                        if (call_at(leds | call_btn, stepped))
                            state_nxt = ARRIVE;
                        else if (ahead_after)
                            timer_nxt = TIMER_LOAD;
                        else
                            state_nxt = IDLE;
                    end
                end
                ARRIVE: begin
                    if (door_done)
                        state_nxt = IDLE;
                end
                STOP: begin
                    if (!emergency)
                        state_nxt = saved;
                end
                default: state_nxt = IDLE;
            endcase
        end

        next_floor_nxt = (state_nxt == MOVE) ? step_floor(floor_nxt, dir_nxt) : floor_nxt;
    end

endmodule

// File: tb/tb_elevator_motion_ctrl.sv
// Self-checking bench for elevator_motion_ctrl: directed scenarios plus a
// randomized run compared against a floor/call-list model of the controller.
module tb_elevator_motion_ctrl;

    localparam int T = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] call_btn;
    logic       emergency;
    logic       door_done;
    logic [1:0] floor, next_floor, open_when;
    logic       open_req, is_mooving, dir_up, st_led, nd_led, rd_led;

    int checks = 0;
    int failures = 0;

    elevator_motion_ctrl #(.TRAVEL_CYCLES(T)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .call_btn   (call_btn),
        .emergency  (emergency),
        .door_done  (door_done),
        .floor      (floor),
        .next_floor (next_floor),
        .open_when  (open_when),
        .open_req   (open_req),
        .is_mooving (is_mooving),
        .dir_up     (dir_up),
        .st_led     (st_led),
        .nd_led     (nd_led),
        .rd_led     (rd_led)
    );

    always #5 clk = ~clk;

    // Behavioural model: cab floor 0..2, call list, and what the cab is doing.
    typedef enum {P_IDLE, P_MOVE, P_DOOR, P_HALT} phase_t;
    int       m_floor;
    bit       m_up;
    bit [2:0] m_calls;
    phase_t   m_phase, m_resume;
    int       m_left;

    function automatic bit any_beyond(input int f, input bit up, input bit [2:0] c);
        for (int j = 0; j < 3; j++)
            if (c[j] && (up ? (j > f) : (j < f)))
                return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_floor  = 0;
        m_up     = 1'b1;
        m_calls  = 3'b000;
        m_phase  = P_IDLE;
        m_resume = P_IDLE;
        m_left   = 0;
    endtask

    task automatic model_step(input bit [2:0] btn, input bit em, input bit dd);
        bit [2:0] nc;
        bit       want_up;
        nc = m_calls | btn;
        if (m_phase == P_DOOR) begin
            nc[m_floor] = m_calls[m_floor];
            if (dd) nc[m_floor] = 1'b0;
        end
        case (m_phase)
            P_IDLE: begin
                want_up = (m_floor == 0) ? 1'b1 : (m_floor == 2) ? 1'b0 : m_up;
                if (em) begin
                    m_resume = P_IDLE;
                    m_phase  = P_HALT;
                end else if (m_calls[m_floor]) begin
                    m_phase = P_DOOR;
                end else if (any_beyond(m_floor, want_up, m_calls)) begin
                    m_up = want_up; m_phase = P_MOVE; m_left = T - 1;
                end else if (any_beyond(m_floor, !want_up, m_calls)) begin
                    m_up = !want_up; m_phase = P_MOVE; m_left = T - 1;
                end
            end
            P_MOVE: begin
                if (em) begin
                    m_resume = P_MOVE;
                    m_phase  = P_HALT;
                end else if (m_left > 0) begin
                    m_left--;
                end else begin
                    m_floor += m_up ? 1 : -1;
                    if (m_calls[m_floor] || btn[m_floor]) m_phase = P_DOOR;
                    else if (any_beyond(m_floor, m_up, m_calls)) m_left = T - 1;
                    else m_phase = P_IDLE;
                end
            end
            P_DOOR: if (dd) m_phase = P_IDLE;
            P_HALT: if (!em) m_phase = m_resume;
            default: m_phase = P_IDLE;
        endcase
        m_calls = nc;
    endtask

    function automatic logic [11:0] model_outputs();
        int nf;
        nf = (m_phase == P_MOVE) ? m_floor + (m_up ? 1 : -1) : m_floor;
        return {2'(m_floor), 2'(nf), 2'(m_floor), m_phase == P_DOOR, m_phase == P_MOVE,
                m_up, m_calls[2], m_calls[1], m_calls[0]};
    endfunction

    logic [11:0] obs;
    assign obs = {floor, next_floor, open_when, open_req, is_mooving, dir_up, rd_led, nd_led, st_led};

    // Drive one cycle of inputs; returns at the following falling edge.
    task automatic apply_stimulus(input logic [2:0] btn, input logic em, input logic dd);
        call_btn  = btn;
        emergency = em;
        door_done = dd;
        @(posedge clk);
        model_step(btn, em, dd);
        @(negedge clk);
    endtask

    task automatic run_until_open(input int max_cycles, output bit found);
        found = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (open_req === 1'b1) begin
                found = 1'b1;
                break;
            end
            apply_stimulus(3'b000, 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (obs !== 12'b00_00_00_0_0_1_000) begin
            failures++;
            $display("[TB] FAIL reset_state: got %b expected %b", obs, 12'b00_00_00_0_0_1_000);
        end
    endtask

    task automatic test_call_top();
        apply_stimulus(3'b100, 1'b0, 1'b0);
        checks++;
        if (rd_led !== 1'b1 || is_mooving !== 1'b0) begin
            failures++; $display("[TB] FAIL top_latch: rd_led=%b mov=%b expected 1 0", rd_led, is_mooving);
        end
        apply_stimulus(3'b000, 1'b0, 1'b0);
        checks++;
        if (is_mooving !== 1'b1 || next_floor !== 2'b01) begin
            failures++; $display("[TB] FAIL top_start: mov=%b next=%b expected 1 01", is_mooving, next_floor);
        end
        for (int i = 0; i < 4; i++) apply_stimulus(3'b000, 1'b0, 1'b0);
        checks++;
        if (floor !== 2'b01 || is_mooving !== 1'b1) begin
            failures++; $display("[TB] FAIL top_leg1: floor=%b mov=%b expected 01 1", floor, is_mooving);
        end
        for (int i = 0; i < 4; i++) apply_stimulus(3'b000, 1'b0, 1'b0);
        checks++;
        if (floor !== 2'b10 || open_req !== 1'b1 || open_when !== 2'b10 || is_mooving !== 1'b0) begin
            failures++;
            $display("[TB] FAIL top_arrive: floor=%b req=%b when=%b mov=%b expected 10 1 10 0",
                     floor, open_req, open_when, is_mooving);
        end
        apply_stimulus(3'b000, 1'b0, 1'b1);
        checks++;
        if (open_req !== 1'b0 || rd_led !== 1'b0) begin
            failures++; $display("[TB] FAIL top_door_done: req=%b rd_led=%b expected 0 0", open_req, rd_led);
        end
    endtask

    task automatic test_same_floor();
        bit found;
        apply_stimulus(3'b001, 1'b0, 1'b0);
        run_until_open(20, found);
        checks++;
        if (!found || floor !== 2'b00) begin
            failures++; $display("[TB] FAIL travel_down: found=%0d floor=%b expected 1 00", found, floor);
        end
        apply_stimulus(3'b000, 1'b0, 1'b1);
        apply_stimulus(3'b001, 1'b0, 1'b0);
        checks++;
        if (st_led !== 1'b1 || is_mooving !== 1'b0 || open_req !== 1'b0) begin
            failures++; $display("[TB] FAIL here_latch: led=%b mov=%b req=%b expected 1 0 0", st_led, is_mooving, open_req);
        end
        apply_stimulus(3'b000, 1'b0, 1'b0);
        checks++;
        if (open_req !== 1'b1 || open_when !== 2'b00 || is_mooving !== 1'b0) begin
            failures++; $display("[TB] FAIL here_arrive: req=%b when=%b mov=%b expected 1 00 0", open_req, open_when, is_mooving);
        end
        apply_stimulus(3'b000, 1'b0, 1'b1);
        checks++;
        if (open_req !== 1'b0 || st_led !== 1'b0) begin
            failures++; $display("[TB] FAIL here_done: req=%b led=%b expected 0 0", open_req, st_led);
        end
    endtask

    task automatic test_intermediate_stop();
        bit found;
        apply_stimulus(3'b100, 1'b0, 1'b0);
        apply_stimulus(3'b010, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) apply_stimulus(3'b000, 1'b0, 1'b0);
        checks++;
        if (floor !== 2'b01 || open_req !== 1'b1 || rd_led !== 1'b1) begin
            failures++; $display("[TB] FAIL mid_stop: floor=%b req=%b rd=%b expected 01 1 1", floor, open_req, rd_led);
        end
        apply_stimulus(3'b000, 1'b0, 1'b1);
        run_until_open(20, found);
        checks++;
        if (!found || floor !== 2'b10) begin
            failures++; $display("[TB] FAIL mid_continue: found=%0d floor=%b expected 1 10", found, floor);
        end
        apply_stimulus(3'b000, 1'b0, 1'b1);
    endtask

    task automatic test_reverse();
        bit found;
        apply_stimulus(3'b001, 1'b0, 1'b0);
        run_until_open(20, found);
        apply_stimulus(3'b000, 1'b0, 1'b1);
        apply_stimulus(3'b010, 1'b0, 1'b0);
        run_until_open(20, found);
        checks++;
        if (!found || floor !== 2'b01 || dir_up !== 1'b1) begin
            failures++; $display("[TB] FAIL rev_setup: found=%0d floor=%b up=%b expected 1 01 1", found, floor, dir_up);
        end
        apply_stimulus(3'b101, 1'b0, 1'b0);
        apply_stimulus(3'b000, 1'b0, 1'b1);
        run_until_open(20, found);
        checks++;
        if (!found || floor !== 2'b10 || dir_up !== 1'b1 || st_led !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rev_first: found=%0d floor=%b up=%b st=%b expected 1 10 1 1", found, floor, dir_up, st_led);
        end
        apply_stimulus(3'b000, 1'b0, 1'b1);
        run_until_open(20, found);
        checks++;
        if (!found || floor !== 2'b00 || dir_up !== 1'b0) begin
            failures++; $display("[TB] FAIL rev_second: found=%0d floor=%b up=%b expected 1 00 0", found, floor, dir_up);
        end
        apply_stimulus(3'b000, 1'b0, 1'b1);
    endtask

    task automatic test_emergency();
        bit found;
        apply_stimulus(3'b100, 1'b0, 1'b0);
        apply_stimulus(3'b000, 1'b0, 1'b0);
        apply_stimulus(3'b000, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(3'b000, 1'b1, 1'b0);
            checks++;
            if (is_mooving !== 1'b0 || floor !== 2'b00) begin
                failures++; $display("[TB] FAIL emerg_hold[%0d]: mov=%b floor=%b expected 0 00", i, is_mooving, floor);
            end
        end
        apply_stimulus(3'b000, 1'b0, 1'b0);
        checks++;
        if (is_mooving !== 1'b1 || floor !== 2'b00) begin
            failures++; $display("[TB] FAIL emerg_resume: mov=%b floor=%b expected 1 00", is_mooving, floor);
        end
        apply_stimulus(3'b000, 1'b0, 1'b0);
        apply_stimulus(3'b000, 1'b0, 1'b0);
        checks++;
        if (floor !== 2'b00) begin
            failures++; $display("[TB] FAIL emerg_early: floor=%b expected 00", floor);
        end
        apply_stimulus(3'b000, 1'b0, 1'b0);
        checks++;
        if (floor !== 2'b01) begin
            failures++; $display("[TB] FAIL emerg_step: floor=%b expected 01", floor);
        end
        run_until_open(20, found);
        apply_stimulus(3'b000, 1'b0, 1'b1);
    endtask

    task automatic test_async_reset();
        apply_stimulus(3'b010, 1'b0, 1'b0);
        apply_stimulus(3'b100, 1'b0, 1'b0);
        apply_stimulus(3'b000, 1'b0, 1'b0);
        checks++;
        if ({rd_led, nd_led, st_led} !== 3'b110 || is_mooving !== 1'b1 || floor !== 2'b10) begin
            failures++;
            $display("[TB] FAIL areset_setup: leds=%b mov=%b floor=%b expected 110 1 10",
                     {rd_led, nd_led, st_led}, is_mooving, floor);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 12'b00_00_00_0_0_1_000) begin
            failures++; $display("[TB] FAIL areset_now: got %b expected %b", obs, 12'b00_00_00_0_0_1_000);
        end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(3'b000, 1'b0, 1'b0);
        checks++;
        if ({rd_led, nd_led, st_led} !== 3'b000 || is_mooving !== 1'b0) begin
            failures++; $display("[TB] FAIL areset_after: leds=%b mov=%b expected 000 0", {rd_led, nd_led, st_led}, is_mooving);
        end
    endtask

    task automatic test_clear_priority();
        bit found;
        apply_stimulus(3'b010, 1'b0, 1'b0);
        run_until_open(20, found);
        checks++;
        if (!found || floor !== 2'b01 || nd_led !== 1'b1) begin
            failures++; $display("[TB] FAIL clr_setup: found=%0d floor=%b nd=%b expected 1 01 1", found, floor, nd_led);
        end
        apply_stimulus(3'b010, 1'b0, 1'b1);
        checks++;
        if (nd_led !== 1'b0 || open_req !== 1'b0) begin
            failures++; $display("[TB] FAIL clr_wins: nd=%b req=%b expected 0 0", nd_led, open_req);
        end
        apply_stimulus(3'b000, 1'b0, 1'b0);
        checks++;
        if (nd_led !== 1'b0 || is_mooving !== 1'b0) begin
            failures++; $display("[TB] FAIL clr_after: nd=%b mov=%b expected 0 0", nd_led, is_mooving);
        end
    endtask

    task automatic test_random();
        int          em_left = 0;
        logic [2:0]  btn;
        logic        em, dd;
        logic [11:0] expv;
        for (int cyc = 0; cyc < 800; cyc++) begin
            btn = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            if (em_left > 0) begin
                em = 1'b1;
                em_left--;
            end else begin
                em = 1'b0;
                if ($urandom_range(0, 40) == 0) em_left = $urandom_range(1, 6);
            end
            dd = ($urandom_range(0, 4) == 0);
            apply_stimulus(btn, em, dd);
            expv = model_outputs();
            checks++;
            if (obs !== expv) begin
                failures++;
                $display("[TB] FAIL random[%0d]: got %b expected %b", cyc, obs, expv);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        call_btn  = 3'b000;
        emergency = 1'b0;
        door_done = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        test_reset();
        test_call_top();
        test_same_floor();
        test_intermediate_stop();
        test_reverse();
        test_emergency();
        test_async_reset();
        test_clear_priority();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
